// File: rtl/econet_line_ctrl.sv
// Econet transmit-side line controller: clock/idle monitoring, line arbitration and flag sequencing.
// Define ECONET_COLLISION_DETECT_EN to abort on rxdata/tx_flag mismatch during flags.
module econet_line_ctrl #(
  parameter int NOCLK_TIMEOUT = 256,
  parameter int IDLE_BITS     = 15,
  parameter int BACKOFF_BITS  = 4,
  parameter int OPEN_FLAGS    = 2,
  parameter int TURN_BITS     = 8
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       netclk,
  input  logic       rxdata,
  input  logic       tx_req,
  input  logic       tx_last,
  input  logic       irq_clr,
  output logic       tx_grant,
  output logic       tx_flag,
  output logic       txen,
  output logic       tx_done,
  output logic       tx_abort,
  output logic [1:0] status,
  output logic       no_clock,
  output logic       idle,
  output logic       irq,
  output logic [2:0] dbg_state
);
  localparam int NCW  = $clog2(NOCLK_TIMEOUT + 1);
  localparam int IBW  = $clog2(IDLE_BITS + 1);
  localparam int FCW  = $clog2(OPEN_FLAGS * 8 + 1);
  localparam int PMAX = (BACKOFF_BITS > TURN_BITS) ? BACKOFF_BITS : TURN_BITS;
  localparam int PCW  = $clog2(PMAX + 1);
  localparam logic [NCW-1:0] NOCLK_MAX = NCW'(NOCLK_TIMEOUT);
  localparam logic [IBW-1:0] IDLE_MAX  = IBW'(IDLE_BITS);
  localparam logic [FCW-1:0] OPEN_LEN  = FCW'(OPEN_FLAGS * 8);
  localparam logic [FCW-1:0] CLOSE_LEN = FCW'(8);
  localparam logic [7:0]     FLAG      = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_BACKOFF = 3'd2,
    S_OPEN    = 3'd3,
    S_DATA    = 3'd4,
    S_CLOSE   = 3'd5,
    S_TURN    = 3'd6
  } state_t;

  state_t         state, state_n;
  logic [2:0]     nclk_s;
  logic [1:0]     rx_s;
  logic           bit_tick, rx_bit;
  logic [NCW-1:0] clk_cnt;
  logic [IBW-1:0] ones_cnt;
  logic [FCW-1:0] flag_cnt, flag_cnt_n;
  logic [PCW-1:0] per_cnt, per_cnt_n;
  logic           tx_flag_n, done_n, abort, coll, in_frame;
  logic           req_armed, no_clock_d;

  // nclk_s[2] is the previous synchronised level, used for rising-edge detection
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      nclk_s <= '0;
      rx_s   <= 2'b11;
    end else begin
      nclk_s <= {nclk_s[1:0], netclk};
      rx_s   <= {rx_s[0], rxdata};
    end
  end

  assign bit_tick = nclk_s[1] & ~nclk_s[2];
  assign rx_bit   = rx_s[1];

  // Counter starts saturated so the controller treats the network as clockless until the first tick
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      clk_cnt  <= NOCLK_MAX;
      ones_cnt <= '0;
    end else begin
      if (bit_tick)                 clk_cnt <= '0;
      else if (clk_cnt != NOCLK_MAX) clk_cnt <= clk_cnt + NCW'(1);
      if (bit_tick) begin
        if (!rx_bit)                  ones_cnt <= '0;
        else if (ones_cnt != IDLE_MAX) ones_cnt <= ones_cnt + IBW'(1);
      end
    end
  end

  assign no_clock = (clk_cnt == NOCLK_MAX);
  assign idle     = (ones_cnt == IDLE_MAX) && !no_clock && !txen;
  assign in_frame = (state == S_BACKOFF) || (state == S_OPEN) ||
                    (state == S_DATA) || (state == S_CLOSE);

`ifdef ECONET_COLLISION_DETECT_EN
  // tx_flag still holds the bit driven on the previous tick; CLOSE with flag_cnt==0 is still data
  assign coll = bit_tick && ((state == S_OPEN) || (state == S_CLOSE && flag_cnt != '0)) &&
                (rx_bit != tx_flag);
`else
  assign coll = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    flag_cnt_n = flag_cnt;
    per_cnt_n  = per_cnt;
    tx_flag_n  = tx_flag;
    done_n     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE:    if (tx_req && !no_clock && req_armed) state_n = S_WAIT;
      S_WAIT: begin
        if (idle) begin
          state_n   = S_BACKOFF;
          per_cnt_n = PCW'(BACKOFF_BITS);
        end
      end
      S_BACKOFF: begin
        if (bit_tick) begin
          if (!rx_bit) state_n = S_WAIT;
          else if (per_cnt == PCW'(1)) begin
            state_n    = S_OPEN;
            tx_flag_n  = FLAG[0];
            flag_cnt_n = FCW'(1);
          end else per_cnt_n = per_cnt - PCW'(1);
        end
      end
      S_OPEN: begin
        if (bit_tick) begin
          if (flag_cnt == OPEN_LEN) begin
            state_n   = S_DATA;
            tx_flag_n = 1'b1;
          end else begin
            tx_flag_n  = FLAG[flag_cnt[2:0]];
            flag_cnt_n = flag_cnt + FCW'(1);
          end
        end
      end
      S_DATA: begin
        if (tx_last) begin
          state_n    = S_CLOSE;
          flag_cnt_n = '0;
        end
      end
      S_CLOSE: begin
        if (bit_tick) begin
          if (flag_cnt == CLOSE_LEN) begin
            state_n   = S_TURN;
            tx_flag_n = 1'b1;
            per_cnt_n = PCW'(TURN_BITS);
          end else begin
            tx_flag_n  = FLAG[flag_cnt[2:0]];
            flag_cnt_n = flag_cnt + FCW'(1);
          end
        end
      end
      S_TURN: begin
        if (bit_tick) begin
          if (per_cnt == PCW'(1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else per_cnt_n = per_cnt - PCW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (in_frame && (no_clock || coll)) begin
      abort     = 1'b1;
      state_n   = S_IDLE;
      tx_flag_n = 1'b1;
    end
    txen     = ((state == S_OPEN) || (state == S_DATA) || (state == S_CLOSE)) && !abort;
    tx_grant = ((state == S_DATA) || (state == S_CLOSE && flag_cnt == '0)) && !abort;
    tx_abort = abort;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      flag_cnt   <= '0;
      per_cnt    <= '0;
      tx_flag    <= 1'b1;
      tx_done    <= 1'b0;
      status     <= 2'd0;
      req_armed  <= 1'b1;
      no_clock_d <= 1'b1;
      irq        <= 1'b0;
    end else begin
      state      <= state_n;
      flag_cnt   <= flag_cnt_n;
      per_cnt    <= per_cnt_n;
      tx_flag    <= tx_flag_n;
      tx_done    <= done_n;
      no_clock_d <= no_clock;
      if (abort)       status <= no_clock ? 2'd1 : 2'd2;
      else if (done_n) status <= 2'd0;
      if (done_n || abort) req_armed <= 1'b0;
      else if (!tx_req)    req_armed <= 1'b1;
      if (tx_done || abort || (no_clock && !no_clock_d)) irq <= 1'b1;
      else if (irq_clr)                                  irq <= 1'b0;
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_econet_line_ctrl.sv
// Directed bench for econet_line_ctrl: netclk at 1/16 mclk, rxdata looped back from the transmitter.
module tb_econet_line_ctrl;
  logic       mclk, reset, netclk, rxdata, tx_req, tx_last, irq_clr;
  logic       tx_grant, tx_flag, txen, tx_done, tx_abort, no_clock, idle, irq;
  logic [1:0] status;
  logic [2:0] dbg_state;
  logic       nc_run, line_zero;
  int         nc_rises = 0;
  time        last_rise = 0;
  int         errors = 0;
  int         checks = 0;

  econet_line_ctrl dut (
    .mclk(mclk), .reset(reset), .netclk(netclk), .rxdata(rxdata),
    .tx_req(tx_req), .tx_last(tx_last), .irq_clr(irq_clr),
    .tx_grant(tx_grant), .tx_flag(tx_flag), .txen(txen), .tx_done(tx_done),
    .tx_abort(tx_abort), .status(status), .no_clock(no_clock), .idle(idle),
    .irq(irq), .dbg_state(dbg_state)
  );

  // Loopback: the line carries what we drive, serialiser data bits are all 1
  assign rxdata = line_zero ? 1'b0 : (txen ? (tx_grant ? 1'b1 : tx_flag) : 1'b1);

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    netclk = 1'b0;
    forever begin
      if (nc_run) begin
        #80 netclk = 1'b1;
        #80 netclk = 1'b0;
      end else #10;
    end
  end

  always @(posedge netclk) begin
    nc_rises  = nc_rises + 1;
    last_rise = $time;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mark;
    int bad;
    time t0;
    logic [15:0] flags;
    logic [7:0]  cflags;

    reset = 1'b0; tx_req = 1'b0; tx_last = 1'b0; irq_clr = 1'b0;
    nc_run = 1'b0; line_zero = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_txen", txen, 0);
    check("rst_grant", tx_grant, 0);
    check("rst_flag", tx_flag, 1);
    check("rst_done", tx_done, 0);
    check("rst_abort", tx_abort, 0);
    check("rst_status", status, 0);
    check("rst_no_clock", no_clock, 1);
    check("rst_idle", idle, 0);
    check("rst_irq", irq, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    repeat (5) @(negedge mclk);
    check("no_clock_after_rst", no_clock, 1);

    // Clock monitor and idle detector
    mark = nc_rises;
    nc_run = 1'b1;
    n = 0;
    while (no_clock && n < 400) begin @(negedge mclk); n++; end
    check("noclk_fall", no_clock, 0);
    check("noclk_fall_first_tick", nc_rises - mark, 1);
    check("idle_low_first_tick", idle, 0);
    n = 0;
    while (!idle && n < 600) begin @(negedge mclk); n++; end
    check("idle_rise", idle, 1);
    check("idle_rise_ticks", nc_rises - mark, 15);

    // Clock loss timeout
    nc_run = 1'b0;
    #400;
    t0 = last_rise;
    #(t0 + 2580 - $time);
    check("noclk_before_timeout", no_clock, 0);
    #10;
    check("noclk_at_timeout", no_clock, 1);
    check("idle_masked_noclk", idle, 0);
    #10;
    check("irq_on_noclk", irq, 1);
    irq_clr = 1'b1; #10; irq_clr = 1'b0;
    check("irq_cleared", irq, 0);

    // Full frame
    nc_run = 1'b1;
    n = 0;
    while (!idle && n < 1000) begin @(negedge mclk); n++; end
    check("idle_before_req", idle, 1);
    @(posedge netclk); #60;
    tx_req = 1'b1;
    mark = nc_rises;
    n = 0;
    while (!txen && n < 1000) begin @(negedge mclk); n++; end
    check("txen_rise", txen, 1);
    check("txen_backoff_ticks", nc_rises - mark, 4);
    flags = '0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin @(posedge netclk); #100; end
      flags[i] = tx_flag;
      if (txen !== 1'b1 || tx_grant !== 1'b0) bad++;
    end
    check("open_flags", flags, 32'h7E7E);
    check("open_txen_nogrant", bad, 0);
    @(posedge netclk); #100;
    check("grant_data", tx_grant, 1);
    check("txen_data", txen, 1);
    check("state_data", dbg_state, 4);
    repeat (2) @(posedge netclk);
    #100;
    tx_last = 1'b1; #10; tx_last = 1'b0;
    cflags = '0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge netclk); #100;
      cflags[i] = tx_flag;
      if (txen !== 1'b1 || tx_grant !== 1'b0) bad++;
    end
    check("close_flag", cflags, 32'h7E);
    check("close_txen_nogrant", bad, 0);
    @(posedge netclk); #100;
    check("txen_off_turn", txen, 0);
    check("state_turn", dbg_state, 6);
    check("mark_turn", tx_flag, 1);
    mark = nc_rises;
    n = 0;
    while (!tx_done && n < 2000) begin @(negedge mclk); n++; end
    check("done_pulse", tx_done, 1);
    check("done_turn_ticks", nc_rises - mark, 8);
    check("done_status", status, 0);
    check("done_state_idle", dbg_state, 0);
    @(negedge mclk);
    check("done_one_cycle", tx_done, 0);
    check("irq_on_done", irq, 1);
    repeat (320) @(negedge mclk);
    check("one_frame_per_req", dbg_state, 0);
    check("no_rearm_txen", txen, 0);
    tx_req = 1'b0;
    irq_clr = 1'b1; #10; irq_clr = 1'b0;

    // Line activity during backoff
    n = 0;
    while (!idle && n < 1000) begin @(negedge mclk); n++; end
    check("idle_before_req2", idle, 1);
    @(posedge netclk); #60;
    tx_req = 1'b1;
    #40 line_zero = 1'b1;
    #120 line_zero = 1'b0;
    #30;
    check("backoff_to_wait", dbg_state, 1);
    check("backoff_no_txen", txen, 0);
    mark = nc_rises;
    n = 0;
    while (!txen && n < 2000) begin @(negedge mclk); n++; end
    check("retry_txen", txen, 1);
    check("retry_ticks", nc_rises - mark, 19);

    // Clock loss during data phase
    n = 0;
    while (!tx_grant && n < 1000) begin @(negedge mclk); n++; end
    check("grant_before_stop", tx_grant, 1);
    check("txen_before_stop", txen, 1);
    nc_run = 1'b0;
    n = 0;
    while (!no_clock && n < 3000) begin @(negedge mclk); n++; end
    check("noclk_in_data", no_clock, 1);
    check("abort_txen_same_cycle", txen, 0);
    check("abort_grant", tx_grant, 0);
    check("abort_pulse", tx_abort, 1);
    @(negedge mclk);
    check("abort_status_noclk", status, 1);
    check("abort_one_cycle", tx_abort, 0);
    check("abort_state_idle", dbg_state, 0);
    check("irq_on_abort", irq, 1);
    tx_req = 1'b0;
    irq_clr = 1'b1; #10; irq_clr = 1'b0;

    // Line forced low during the first 1-bit of the opening flag
    nc_run = 1'b1;
    n = 0;
    while (!idle && n < 1000) begin @(negedge mclk); n++; end
    check("idle_before_req3", idle, 1);
    @(posedge netclk); #60;
    tx_req = 1'b1;
    n = 0;
    while (!txen && n < 1000) begin @(negedge mclk); n++; end
    check("txen_rise3", txen, 1);
    @(posedge netclk); #50;
    line_zero = 1'b1;
`ifdef ECONET_COLLISION_DETECT_EN
    n = 0;
    while (!tx_abort && n < 400) begin @(negedge mclk); n++; end
    check("coll_abort", tx_abort, 1);
    check("coll_txen_off", txen, 0);
    @(negedge mclk);
    check("coll_status", status, 2);
    line_zero = 1'b0;
`else
    @(posedge netclk); #100;
    check("nocoll_txen", txen, 1);
    check("nocoll_state_open", dbg_state, 3);
    line_zero = 1'b0;
    n = 0;
    while (!tx_grant && n < 1000) begin @(negedge mclk); n++; end
    check("nocoll_grant", tx_grant, 1);
    tx_last = 1'b1; #10; tx_last = 1'b0;
    n = 0;
    while (!tx_done && n < 1000) begin @(negedge mclk); n++; end
    check("nocoll_done", tx_done, 1);
    check("nocoll_status", status, 0);
`endif
    tx_req = 1'b0;
    repeat (5) @(negedge mclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
